// File: rtl/shift_sequencer_pkg.sv
// shift_seq_pkg: op/state encodings and width defaults shared by the shift sequencer slice
package shift_seq_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] OP_ROTL = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_SRL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result valid-ready bus of the shift sequencer
interface shift_sequencer_if;
    import shift_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_op;
    logic [CNT_W-1:0]  req_cnt;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;

    modport master (
        output req_valid, req_data, req_op, req_cnt, res_ready,
        input  req_ready, res_valid, res_data, busy
    );

    modport slave (
        input  req_valid, req_data, req_op, req_cnt, res_ready,
        output req_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_sequencer_shifter_1.sv
// shifter_1: single-step 16-bit rotl/sll/sra/srl; passes the operand through when sh=0
module shifter_1
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        op,
    input  logic              sh,
    output logic [DATA_W-1:0] out
);
    // one-bit step selected by op
    always_comb
        out = !sh            ? in :
              op == OP_ROTL  ? {in[DATA_W-2:0], in[DATA_W-1]} :
              op == OP_SLL   ? {in[DATA_W-2:0], 1'b0} :
              op == OP_SRA   ? {in[DATA_W-1], in[DATA_W-1:1]} :
                               {1'b0, in[DATA_W-1:1]};
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter iterating shifter_1 once per cycle; abort port with SHIFT_SEQ_ABORT_EN
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic abort,
`endif
    shift_sequencer_if.slave bus
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_r, data_d, sh_out;
    logic [1:0]        op_r, op_d;
    logic [CNT_W-1:0]  rem, rem_d;
    logic              kill;

`ifdef SHIFT_SEQ_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    shifter_1 u_sh (
        .in  (data_r),
        .op  (op_r),
        .sh  (1'b1),
        .out (sh_out)
    );

    // state and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_r  <= '0;
            op_r    <= OP_ROTL;
            rem     <= '0;
        end else begin
            state_q <= state_d;
            data_r  <= data_d;
            op_r    <= op_d;
            rem     <= rem_d;
        end
    end

    // next state: load in IDLE, step in SHIFT, hold in DONE until taken; abort wins outside IDLE
    always_comb begin
        state_d = state_q;
        data_d  = data_r;
        op_d    = op_r;
        rem_d   = rem;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                data_d  = bus.req_data;
                op_d    = bus.req_op;
                rem_d   = bus.req_cnt;
                state_d = bus.req_cnt == '0 ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                data_d  = sh_out;
                rem_d   = rem - CNT_W'(1);
                state_d = rem == CNT_W'(1) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: state_d = bus.res_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (kill && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            data_d  = data_r;
            rem_d   = rem;
        end
    end

    assign bus.req_ready = state_q == ST_IDLE;
    assign bus.res_valid = state_q == ST_DONE;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.res_data  = data_r;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of shift_sequencer (abort step with SHIFT_SEQ_ABORT_EN)
module tb_shift_sequencer;
    logic clk = 0;
    logic rst_n = 0;
    int vectors = 0;
    int miscompares = 0;
`ifdef SHIFT_SEQ_ABORT_EN
    logic abort = 0;
`endif

    shift_sequencer_if bus();

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [15:0] d, input logic [1:0] op, input logic [3:0] cnt);
        bus.req_valid = 1;
        bus.req_data  = d;
        bus.req_op    = op;
        bus.req_cnt   = cnt;
        tick();
        bus.req_valid = 0;
        bus.req_data  = 16'hDEAD;
        bus.req_op    = ~op;
        bus.req_cnt   = 4'h7;
    endtask

    task automatic run(input string tag, input logic [15:0] d, input logic [1:0] op,
                       input logic [3:0] cnt, input logic [15:0] exp);
        int n;
        accept(d, op, cnt);
        n = 0;
        while (!bus.res_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'(cnt));
        chk({tag, "_data"}, bus.res_data, exp);
        tick();
        chk({tag, "_idle"}, {15'd0, bus.req_ready}, 16'd1);
    endtask

    initial begin
        logic seen;
        bus.req_valid = 0;
        bus.req_data  = 0;
        bus.req_op    = 0;
        bus.req_cnt   = 0;
        bus.res_ready = 1;
        #12;
        chk("rst_req_ready", {15'd0, bus.req_ready}, 16'd1);
        chk("rst_res_valid", {15'd0, bus.res_valid}, 16'd0);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_res_data", bus.res_data, 16'h0000);
        rst_n = 1;
        tick();
        accept(16'h00FF, 2'b01, 4'd8);
        tick();
        tick();
        chk("mid_busy", {15'd0, bus.busy}, 16'd1);
        rst_n = 0;
        #1;
        chk("mrst_req_ready", {15'd0, bus.req_ready}, 16'd1);
        chk("mrst_res_valid", {15'd0, bus.res_valid}, 16'd0);
        chk("mrst_busy", {15'd0, bus.busy}, 16'd0);
        tick();
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= bus.res_valid;
        end
        chk("mrst_no_valid", {15'd0, seen}, 16'd0);
        run("sll4", 16'h0001, 2'b01, 4'd4, 16'h0010);
        run("sra15", 16'h8000, 2'b10, 4'd15, 16'hFFFF);
        run("srl15", 16'h8000, 2'b11, 4'd15, 16'h0001);
        run("rotl1", 16'h8001, 2'b00, 4'd1, 16'h0003);
        run("cnt0", 16'h1234, 2'b00, 4'd0, 16'h1234);
        run("rotl4", 16'hA5C3, 2'b00, 4'd4, 16'h5C3A);
        run("sra3", 16'h9000, 2'b10, 4'd3, 16'hF200);
        bus.res_ready = 0;
        accept(16'h00F0, 2'b01, 4'd2);
        tick();
        tick();
        chk("bp_valid0", {15'd0, bus.res_valid}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1;
            bus.req_data  = 16'h5555;
            bus.req_cnt   = 4'd0;
            chk("bp_req_ready", {15'd0, bus.req_ready}, 16'd0);
            tick();
            chk("bp_valid", {15'd0, bus.res_valid}, 16'd1);
            chk("bp_data", bus.res_data, 16'h03C0);
        end
        bus.req_valid = 0;
        bus.res_ready = 1;
        tick();
        chk("bp_idle", {15'd0, bus.req_ready}, 16'd1);
        tick();
        chk("bp_not_taken", {15'd0, bus.busy}, 16'd0);
`ifdef SHIFT_SEQ_ABORT_EN
        accept(16'h0001, 2'b01, 4'd8);
        tick();
        abort = 1;
        tick();
        abort = 0;
        chk("ab_req_ready", {15'd0, bus.req_ready}, 16'd1);
        chk("ab_busy", {15'd0, bus.busy}, 16'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= bus.res_valid;
        end
        chk("ab_no_valid", {15'd0, seen}, 16'd0);
        run("ab_next", 16'h0003, 2'b01, 4'd2, 16'h000C);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
